// File: rtl/mac_accumulator.sv
// Two-stage multiply-accumulate back end: capture register, then accumulator/flag register.
// Define MAC_SATURATE_EN to clamp ADD overflow to all ones and SUB underflow to zero instead of wrapping.
module mac_accumulator #(
  parameter int ACC_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [7:0]       product,
  input  logic [1:0]       op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] acc_out,
  output logic             zero,
  output logic             ovf,
  output logic             ovf_sticky,
  output logic [7:0]       acc_cnt
);

  typedef enum logic [1:0] {
    OP_LOAD  = 2'b00,
    OP_ADD   = 2'b01,
    OP_SUB   = 2'b10,
    OP_CLEAR = 2'b11
  } op_e;

  logic       s1_v;
  logic [7:0] s1_prod;
  op_e        s1_op;

  logic adv;
  logic take;

  assign adv      = s1_v && (!out_valid || out_ready);
  assign in_ready = !s1_v || adv;
  assign take     = in_valid && in_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_v    <= 1'b0;
      s1_prod <= '0;
      s1_op   <= OP_LOAD;
    end else if (take) begin
      s1_v    <= 1'b1;
      s1_prod <= product;
      s1_op   <= op_e'(op);
    end else if (adv) begin
      s1_v    <= 1'b0;
    end
  end

  logic [ACC_W:0]   prod_x;
  logic [ACC_W:0]   sum;
  logic [ACC_W:0]   diff;
  logic             carry;
  logic             borrow;
  logic [7:0]       cnt_inc;
  logic [ACC_W-1:0] acc_nxt;
  logic             ovf_nxt;
  logic             sticky_nxt;
  logic [7:0]       cnt_nxt;

  assign prod_x  = {{(ACC_W-7){1'b0}}, s1_prod};
  assign sum     = {1'b0, acc_out} + prod_x;
  assign diff    = {1'b0, acc_out} - prod_x;
  assign carry   = sum[ACC_W];
  assign borrow  = prod_x > {1'b0, acc_out};
  assign cnt_inc = (acc_cnt == 8'hFF) ? acc_cnt : acc_cnt + 8'd1;

  always_comb begin
    acc_nxt    = acc_out;
    ovf_nxt    = ovf;
    sticky_nxt = ovf_sticky;
    cnt_nxt    = acc_cnt;
    case (s1_op)
      OP_LOAD: begin
        acc_nxt    = prod_x[ACC_W-1:0];
        ovf_nxt    = 1'b0;
        sticky_nxt = 1'b0;
        cnt_nxt    = '0;
      end
      OP_ADD: begin
`ifdef MAC_SATURATE_EN
        acc_nxt    = carry ? '1 : sum[ACC_W-1:0];
`else
        acc_nxt    = sum[ACC_W-1:0];
`endif
        ovf_nxt    = carry;
        sticky_nxt = ovf_sticky | carry;
        cnt_nxt    = cnt_inc;
      end
      OP_SUB: begin
`ifdef MAC_SATURATE_EN
        acc_nxt    = borrow ? '0 : diff[ACC_W-1:0];
`else
        acc_nxt    = diff[ACC_W-1:0];
`endif
        ovf_nxt    = borrow;
        sticky_nxt = ovf_sticky | borrow;
        cnt_nxt    = cnt_inc;
      end
      OP_CLEAR: begin
        acc_nxt    = '0;
        ovf_nxt    = 1'b0;
        sticky_nxt = 1'b0;
        cnt_nxt    = '0;
      end
      default: begin
        acc_nxt    = acc_out;
      end
    endcase
  end

  // acc_out is the accumulator itself, so it keeps its value after out_valid drops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_out    <= '0;
      ovf        <= 1'b0;
      ovf_sticky <= 1'b0;
      acc_cnt    <= '0;
      out_valid  <= 1'b0;
    end else if (adv) begin
      acc_out    <= acc_nxt;
      ovf        <= ovf_nxt;
      ovf_sticky <= sticky_nxt;
      acc_cnt    <= cnt_nxt;
      out_valid  <= 1'b1;
    end else if (out_valid && out_ready) begin
      out_valid  <= 1'b0;
    end
  end

  assign zero = (acc_out == '0);

  hold_while_stalled: assert property (@(posedge clk) disable iff (!rst_n)
    (out_valid && !out_ready) |=> (out_valid && $stable(acc_out) && $stable(ovf)
                                   && $stable(ovf_sticky) && $stable(acc_cnt)));

endmodule

// File: tb/tb_mac_accumulator.sv
// Scoreboard bench for mac_accumulator: a 16-bit instance for most vectors, a 9-bit one for overflow.
module tb_mac_accumulator;

`ifdef MAC_SATURATE_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  typedef struct {
    logic [15:0] acc;
    logic        zero;
    logic        ovf;
    logic        sticky;
    logic [7:0]  cnt;
    bit          gap;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  logic        in_valid = 1'b0, in_ready, out_valid, out_ready = 1'b1;
  logic [7:0]  product = '0;
  logic [1:0]  op = '0;
  logic [15:0] acc_out;
  logic        zero, ovf, ovf_sticky;
  logic [7:0]  acc_cnt;

  logic        in_valid9 = 1'b0, in_ready9, out_valid9, out_ready9 = 1'b1;
  logic [7:0]  product9 = '0;
  logic [1:0]  op9 = '0;
  logic [8:0]  acc_out9;
  logic        zero9, ovf9, ovf_sticky9;
  logic [7:0]  acc_cnt9;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int last_pop = -10;
  exp_t q[$];
  exp_t q9[$];

  mac_accumulator #(.ACC_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .product(product), .op(op), .out_valid(out_valid), .out_ready(out_ready),
    .acc_out(acc_out), .zero(zero), .ovf(ovf), .ovf_sticky(ovf_sticky), .acc_cnt(acc_cnt)
  );

  mac_accumulator #(.ACC_W(9)) dut9 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid9), .in_ready(in_ready9),
    .product(product9), .op(op9), .out_valid(out_valid9), .out_ready(out_ready9),
    .acc_out(acc_out9), .zero(zero9), .ovf(ovf9), .ovf_sticky(ovf_sticky9), .acc_cnt(acc_cnt9)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic exp_t mk(input logic [15:0] a, input logic z, input logic o,
                              input logic s, input logic [7:0] c, input bit g);
    exp_t e;
    e.acc = a; e.zero = z; e.ovf = o; e.sticky = s; e.cnt = c; e.gap = g;
    return e;
  endfunction

  always @(negedge clk) begin : mon16
    exp_t e;
    if (out_valid && out_ready) begin
      checks++;
      if (q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_beat16 acc_out=%h cnt=%0d", acc_out, acc_cnt);
      end else begin
        e = q.pop_front();
        if (acc_out !== e.acc || zero !== e.zero || ovf !== e.ovf ||
            ovf_sticky !== e.sticky || acc_cnt !== e.cnt) begin
          errors++;
          $display("FAIL beat16 got acc=%h z=%b ovf=%b st=%b cnt=%0d exp acc=%h z=%b ovf=%b st=%b cnt=%0d",
                   acc_out, zero, ovf, ovf_sticky, acc_cnt, e.acc, e.zero, e.ovf, e.sticky, e.cnt);
        end
        if (e.gap) begin
          checks++;
          if (cyc != last_pop + 1) begin
            errors++;
            $display("FAIL throughput got cycle %0d exp %0d", cyc, last_pop + 1);
          end
        end
      end
      last_pop = cyc;
    end
  end

  always @(negedge clk) begin : mon9
    exp_t e;
    if (out_valid9 && out_ready9) begin
      checks++;
      if (q9.size() == 0) begin
        errors++;
        $display("FAIL unexpected_beat9 acc_out=%h", acc_out9);
      end else begin
        e = q9.pop_front();
        if ({7'd0, acc_out9} !== e.acc || zero9 !== e.zero || ovf9 !== e.ovf ||
            ovf_sticky9 !== e.sticky || acc_cnt9 !== e.cnt) begin
          errors++;
          $display("FAIL beat9 got acc=%h z=%b ovf=%b st=%b cnt=%0d exp acc=%h z=%b ovf=%b st=%b cnt=%0d",
                   acc_out9, zero9, ovf9, ovf_sticky9, acc_cnt9, e.acc[8:0], e.zero, e.ovf, e.sticky, e.cnt);
        end
      end
    end
  end

  // Called at posedge+1; returns at posedge+1 just after the accepting edge.
  task automatic send(input logic [7:0] p, input logic [1:0] o, input exp_t e);
    int budget;
    budget = 0;
    in_valid = 1'b1; product = p; op = o;
    @(negedge clk);
    while (!in_ready && budget < 50) begin
      budget++;
      @(negedge clk);
    end
    if (!in_ready) begin
      checks++; errors++;
      $display("FAIL send_timeout in_ready=%b exp 1", in_ready);
    end else begin
      q.push_back(e);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic send9(input logic [7:0] p, input logic [1:0] o, input exp_t e);
    int budget;
    budget = 0;
    in_valid9 = 1'b1; product9 = p; op9 = o;
    @(negedge clk);
    while (!in_ready9 && budget < 50) begin
      budget++;
      @(negedge clk);
    end
    if (!in_ready9) begin
      checks++; errors++;
      $display("FAIL send9_timeout in_ready=%b exp 1", in_ready9);
    end else begin
      q9.push_back(e);
    end
    @(posedge clk); #1;
    in_valid9 = 1'b0;
  endtask

  task automatic check_reset(input string name);
    logic [29:0] act, expv;
    act  = {in_ready, out_valid, acc_out, zero, ovf, ovf_sticky, acc_cnt};
    expv = {1'b1, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 8'h00};
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s got %h exp %h", name, act, expv);
    end
  endtask

  task automatic check_bit(input string name, input logic act, input logic expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s got %b exp %b", name, act, expv);
    end
  endtask

  task automatic drain();
    repeat (4) @(posedge clk);
    #1;
  endtask

  initial begin
    int budget;
    logic quiet;
    repeat (2) @(negedge clk);
    check_reset("reset_values");
    @(posedge clk); #1;
    rst_n = 1'b1;

    // LOAD 0x2A and its two-cycle latency
    send(8'h2A, 2'b00, mk(16'h002A, 1'b0, 1'b0, 1'b0, 8'd0, 1'b0));
    check_bit("latency_s1", out_valid, 1'b0);
    @(posedge clk); #1;
    check_bit("latency_out", out_valid, 1'b1);
    drain();

    // back-to-back ADDs at full throughput
    send(8'hFF, 2'b00, mk(16'h00FF, 1'b0, 1'b0, 1'b0, 8'd0, 1'b0));
    send(8'hFF, 2'b01, mk(16'h01FE, 1'b0, 1'b0, 1'b0, 8'd1, 1'b1));
    send(8'hFF, 2'b01, mk(16'h02FD, 1'b0, 1'b0, 1'b0, 8'd2, 1'b1));
    send(8'hFF, 2'b01, mk(16'h03FC, 1'b0, 1'b0, 1'b0, 8'd3, 1'b1));
    drain();

    // underflow then sticky flag persistence
    send(8'h05, 2'b00, mk(16'h0005, 1'b0, 1'b0, 1'b0, 8'd0, 1'b0));
    send(8'h06, 2'b10, mk(SAT ? 16'h0000 : 16'hFFFF, SAT, 1'b1, 1'b1, 8'd1, 1'b0));
    send(8'h00, 2'b01, mk(SAT ? 16'h0000 : 16'hFFFF, SAT, 1'b0, 1'b1, 8'd2, 1'b0));
    drain();

    // overflow at ACC_W=9
    send9(8'hFF, 2'b00, mk(16'h00FF, 1'b0, 1'b0, 1'b0, 8'd0, 1'b0));
    send9(8'hFF, 2'b01, mk(16'h01FE, 1'b0, 1'b0, 1'b0, 8'd1, 1'b0));
    send9(8'hFF, 2'b01, mk(SAT ? 16'h01FF : 16'h00FD, 1'b0, 1'b1, 1'b1, 8'd2, 1'b0));
    drain();

    // backpressure: two beats fill the pipe, the third waits
    out_ready = 1'b0;
    send(8'h10, 2'b00, mk(16'h0010, 1'b0, 1'b0, 1'b0, 8'd0, 1'b0));
    send(8'h02, 2'b01, mk(16'h0012, 1'b0, 1'b0, 1'b0, 8'd1, 1'b0));
    in_valid = 1'b1; product = 8'h03; op = 2'b10;
    q.push_back(mk(16'h000F, 1'b0, 1'b0, 1'b0, 8'd2, 1'b0));
    quiet = 1'b1;
    repeat (3) begin
      @(negedge clk);
      if (in_ready !== 1'b0 || out_valid !== 1'b1 || acc_out !== 16'h0010 || acc_cnt !== 8'd0)
        quiet = 1'b0;
    end
    check_bit("stall_hold", quiet, 1'b1);
    @(posedge clk); #1;
    out_ready = 1'b1;
    budget = 0;
    @(negedge clk);
    while (!in_ready && budget < 20) begin
      budget++;
      @(negedge clk);
    end
    check_bit("stall_release", in_ready, 1'b1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    drain();

    // asynchronous reset with two beats in flight
    out_ready = 1'b0;
    send(8'h07, 2'b00, mk(16'h0007, 1'b0, 1'b0, 1'b0, 8'd0, 1'b0));
    send(8'h01, 2'b01, mk(16'h0008, 1'b0, 1'b0, 1'b0, 8'd1, 1'b0));
    rst_n = 1'b0;
    #1;
    check_reset("async_reset");
    q.delete();
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    out_ready = 1'b1;
    quiet = 1'b1;
    repeat (4) begin
      @(negedge clk);
      if (out_valid !== 1'b0) quiet = 1'b0;
    end
    check_bit("no_spurious", quiet, 1'b1);
    @(posedge clk); #1;

    // count saturation, then CLEAR
    for (int k = 1; k <= 300; k++)
      send(8'h00, 2'b01, mk(16'h0000, 1'b1, 1'b0, 1'b0, (k < 255) ? 8'(k) : 8'd255, 1'b0));
    send(8'h55, 2'b11, mk(16'h0000, 1'b1, 1'b0, 1'b0, 8'd0, 1'b0));

    budget = 0;
    while ((q.size() != 0 || q9.size() != 0) && budget < 100) begin
      budget++;
      @(posedge clk);
    end
    #1;
    checks++;
    if (q.size() != 0 || q9.size() != 0) begin
      errors++;
      $display("FAIL drain_timeout got %0d/%0d pending exp 0/0", q.size(), q9.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
